// File: rtl/qspi_pkg.sv
// Shared definitions for the QSPI SRAM controllers: opcodes, FSM encoding,
// fixed phase lengths and the nibble helpers used to build SIO output data.
package qspi_pkg;

    localparam logic [7:0] QPIRD    = 8'hEB;
    localparam logic [7:0] QPIWR    = 8'h38;

    localparam int         CMD_CYC  = 8;
    localparam int         ADDR_CYC = 6;

    // SIO3 = HOLD# inactive, SIO2 = WP# inactive, SIO1/SIO0 low
    localparam logic [3:0] SIO_IDLE = 4'b1100;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        ADDR  = 3'd2,
        DUMMY = 3'd3,
        DATA  = 3'd4,
        DONE  = 3'd5
    } qspi_state_t;

    // Command phase: one opcode bit per SCK on SIO0, MSB first.
    function automatic logic [3:0] cmd_nibble(input logic [7:0] op, input logic [2:0] idx);
        logic [7:0] sh;
        sh = op << idx;
        return {SIO_IDLE[3:1], sh[7]};
    endfunction

    // Address phase: one nibble per SCK, most significant nibble first.
    function automatic logic [3:0] addr_nibble(input logic [23:0] a, input logic [2:0] idx);
        logic [23:0] sh;
        sh = a << {idx, 2'b00};
        return sh[23:20];
    endfunction

endpackage

// File: rtl/qspi_phy.sv
// QSPI pin layer: SCK generation at clk/2, the end-of-phase-H sample strobe,
// and the registered SIO output nibble / output-enable, updated on phase-L entry.
module qspi_phy
    import qspi_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       load,
    input  logic [3:0] nib_d,
    input  logic       oe_d,
    output logic       sck,
    output logic       sample,
    output logic [3:0] sio_out,
    output logic       oe
);

    logic       sck_r;
    logic       oe_r;
    logic [3:0] out_r;

    // A sample edge is the clock that ends phase H (SCK falls here)
    assign sample  = run & sck_r;
    assign sck     = sck_r;
    assign oe      = oe_r;
    assign sio_out = out_r;

    // SCK toggles every clock while running and parks low otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_r <= 1'b0;
        end else if (run) begin
            sck_r <= ~sck_r;
        end else begin
            sck_r <= 1'b0;
        end
    end

    // Output nibble and direction change only when a phase L is entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r <= 4'h0;
            oe_r  <= 1'b0;
        end else if (load) begin
            out_r <= nib_d;
            oe_r  <= oe_d;
        end else begin
            out_r <= out_r;
            oe_r  <= oe_r;
        end
    end

endmodule

// File: rtl/qspi_sram_reader.sv
// Quad Read (0xEB) engine: fetches word_cnt 32-bit words from the QSPI SRAM
// starting at start_addr and writes them to the RAM2/RAM3 buffer from word 0.
module qspi_sram_reader
    import qspi_pkg::*;
#(
    parameter int         DUMMY_CYC = 6,
    parameter int         RAM_AW    = 10,
    parameter logic [7:0] RD_OPCODE = 8'hEB
) (
    input  logic              WBs_CLK_i,
    input  logic              WBs_RST_n_i,
    input  logic              start_i,
    input  logic [23:0]       start_addr_i,
    input  logic [RAM_AW:0]   word_cnt_i,
    input  logic [3:0]        QUAD_In_i,
    output logic [3:0]        QUAD_Out_o,
    output logic              QUAD_oe_o,
    output logic              QSPI_SCK_o,
    output logic              QSPI_nCE_o,
    output logic [RAM_AW-1:0] ram_wa_o,
    output logic [31:0]       ram_wd_o,
    output logic              ram_we_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [RAM_AW:0]   words_done_o
);

    localparam logic [7:0]      CMD_LAST   = 8'(CMD_CYC - 1);
    localparam logic [7:0]      ADDR_LAST  = 8'(ADDR_CYC - 1);
    localparam logic [7:0]      DUMMY_LAST = 8'(DUMMY_CYC - 1);
    localparam logic [7:0]      NIB_LAST   = 8'd7;
    localparam logic [RAM_AW:0] WCNT_ZERO  = {(RAM_AW+1){1'b0}};
    localparam logic [RAM_AW:0] WCNT_ONE   = {{RAM_AW{1'b0}}, 1'b1};

    qspi_state_t        state_r, state_s;
    logic [7:0]         cnt_r, cnt_s;
    logic [23:0]        addr_r;
    logic [RAM_AW:0]    left_r;
    logic [27:0]        shreg_r;
    logic               nce_r;
    logic               busy_r;
    logic               done_r;
    logic               we_r;
    logic [RAM_AW-1:0]  wa_r;
    logic [31:0]        wd_r;
    logic [RAM_AW:0]    wdone_r;

    logic               accept_s;
    logic               run_s;
    logic               load_s;
    logic [3:0]         nib_s;
    logic               oe_s;
    logic               sample_s;
    logic               word_end_s;

    assign accept_s   = (state_r == IDLE) && start_i;
    assign word_end_s = (state_r == DATA) && sample_s && (cnt_r == NIB_LAST);

    qspi_phy u_phy (
        .clk     (WBs_CLK_i),
        .rst_n   (WBs_RST_n_i),
        .run     (run_s),
        .load    (load_s),
        .nib_d   (nib_s),
        .oe_d    (oe_s),
        .sck     (QSPI_SCK_o),
        .sample  (sample_s),
        .sio_out (QUAD_Out_o),
        .oe      (QUAD_oe_o)
    );

    // FSM state and per-phase SCK period counter
    always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
        if (!WBs_RST_n_i) begin
            state_r <= IDLE;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next state: phases advance only on sample edges, DONE lasts two clocks
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    cnt_s   = 8'd0;
                    state_s = (word_cnt_i == WCNT_ZERO) ? DONE : CMD;
                end else begin
                    state_s = IDLE;
                end
            end
            CMD: begin
                if (sample_s) begin
                    if (cnt_r == CMD_LAST) begin
                        state_s = ADDR;
                        cnt_s   = 8'd0;
                    end else begin
                        cnt_s   = cnt_r + 8'd1;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ADDR: begin
                if (sample_s) begin
                    if (cnt_r == ADDR_LAST) begin
                        state_s = (DUMMY_CYC == 0) ? DATA : DUMMY;
                        cnt_s   = 8'd0;
                    end else begin
                        cnt_s   = cnt_r + 8'd1;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            DUMMY: begin
                if (sample_s) begin
                    if (cnt_r == DUMMY_LAST) begin
                        state_s = DATA;
                        cnt_s   = 8'd0;
                    end else begin
                        cnt_s   = cnt_r + 8'd1;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            DATA: begin
                if (sample_s) begin
                    if (cnt_r == NIB_LAST) begin
                        cnt_s   = 8'd0;
                        state_s = (left_r == WCNT_ONE) ? DONE : DATA;
                    end else begin
                        cnt_s   = cnt_r + 8'd1;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            DONE: begin
                if (cnt_r == 8'd1) begin
                    state_s = IDLE;
                    cnt_s   = 8'd0;
                end else begin
                    cnt_s   = cnt_r + 8'd1;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 8'd0;
            end
        endcase
    end

    // PHY controls: nibble/oe for the SCK period that begins after this edge
    always_comb begin
        run_s  = (state_r inside {CMD, ADDR, DUMMY, DATA});
        load_s = accept_s || sample_s;
        nib_s  = 4'h0;
        oe_s   = 1'b0;
        case (state_s)
            CMD: begin
                nib_s = cmd_nibble(RD_OPCODE, cnt_s[2:0]);
                oe_s  = 1'b1;
            end
            ADDR: begin
                nib_s = addr_nibble(addr_r, cnt_s[2:0]);
                oe_s  = 1'b1;
            end
            default: begin
                nib_s = 4'h0;
                oe_s  = 1'b0;
            end
        endcase
    end

    // Transfer bookkeeping: parameters, chip enable, busy and done pulse
    always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
        if (!WBs_RST_n_i) begin
            addr_r <= 24'h0;
            left_r <= WCNT_ZERO;
            nce_r  <= 1'b1;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            nce_r  <= !(state_s inside {CMD, ADDR, DUMMY, DATA});
            done_r <= (state_r == DONE) && (cnt_r == 8'd1);
            if (accept_s) begin
                addr_r <= start_addr_i;
                left_r <= word_cnt_i;
                busy_r <= 1'b1;
            end else if ((state_r == DONE) && (cnt_r == 8'd1)) begin
                busy_r <= 1'b0;
            end else begin
                busy_r <= busy_r;
                if (word_end_s) begin
                    left_r <= left_r - WCNT_ONE;
                end else begin
                    left_r <= left_r;
                end
            end
        end
    end

    // Data path: shift in nibbles MSB first and emit one RAM write per word
    always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
        if (!WBs_RST_n_i) begin
            shreg_r <= 28'h0;
            we_r    <= 1'b0;
            wa_r    <= {RAM_AW{1'b0}};
            wd_r    <= 32'h0;
            wdone_r <= WCNT_ZERO;
        end else begin
            we_r <= word_end_s;
            if ((state_r == DATA) && sample_s) begin
                shreg_r <= {shreg_r[23:0], QUAD_In_i};
            end else begin
                shreg_r <= shreg_r;
            end
            if (accept_s) begin
                wdone_r <= WCNT_ZERO;
            end else if (word_end_s) begin
                wd_r    <= {shreg_r, QUAD_In_i};
                wa_r    <= wdone_r[RAM_AW-1:0];
                wdone_r <= wdone_r + WCNT_ONE;
            end else begin
                wdone_r <= wdone_r;
            end
        end
    end

    assign QSPI_nCE_o   = nce_r;
    assign busy_o       = busy_r;
    assign done_o       = done_r;
    assign ram_we_o     = we_r;
    assign ram_wa_o     = wa_r;
    assign ram_wd_o     = wd_r;
    assign words_done_o = wdone_r;

endmodule

// File: tb/tb_qspi_sram_reader.sv
// Directed bench for qspi_sram_reader with a behavioural Quad-Read SRAM model.
module tb_qspi_sram_reader;

    localparam int DUM = 6;
    localparam int AW  = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [23:0]   saddr = 24'h0;
    logic [AW:0]   wcnt = '0;
    logic [3:0]    qin;
    logic [3:0]    sram_q = 4'h0;
    logic [3:0]    tog_q = 4'h0;
    logic          tog = 1'b1;
    logic [3:0]    qout;
    logic          oe, sck, nce, we, busy, done;
    logic [AW-1:0] wa;
    logic [31:0]   wd;
    logic [AW:0]   wdone;

    assign qin = tog ? tog_q : sram_q;

    always #5 clk = ~clk;

    qspi_sram_reader #(.DUMMY_CYC(DUM), .RAM_AW(AW), .RD_OPCODE(8'hEB)) dut (
        .WBs_CLK_i    (clk),
        .WBs_RST_n_i  (rst_n),
        .start_i      (start),
        .start_addr_i (saddr),
        .word_cnt_i   (wcnt),
        .QUAD_In_i    (qin),
        .QUAD_Out_o   (qout),
        .QUAD_oe_o    (oe),
        .QSPI_SCK_o   (sck),
        .QSPI_nCE_o   (nce),
        .ram_wa_o     (wa),
        .ram_wd_o     (wd),
        .ram_we_o     (we),
        .busy_o       (busy),
        .done_o       (done),
        .words_done_o (wdone)
    );

    int gcyc = 0;
    always @(posedge clk) gcyc <= gcyc + 1;

    // Transfer monitor, sampled on the falling clock edge
    int          s0 = 0, wr_n = 0, wa_bad = 0, nce_low = 0, done_n = 0;
    int          done_rel = -1, first_we_rel = -1, oe_fall_rel = -1;
    logic [31:0] last_wd = 32'h0;
    logic        oe_prev = 1'b0;
    always @(negedge clk) begin
        if (start && !busy) begin
            s0 <= gcyc; wr_n <= 0; wa_bad <= 0; nce_low <= 0; done_n <= 0;
            done_rel <= -1; first_we_rel <= -1; oe_fall_rel <= -1;
        end else begin
            if (we) begin
                if (wr_n == 0) first_we_rel <= gcyc - s0;
                if (int'(wa) != (wr_n % 1024)) wa_bad <= wa_bad + 1;
                last_wd <= wd;
                wr_n <= wr_n + 1;
            end
            if (!nce) nce_low <= nce_low + 1;
            if (done) begin
                done_n <= done_n + 1;
                done_rel <= gcyc - s0;
            end
            if (oe_prev && !oe && oe_fall_rel < 0) oe_fall_rel <= gcyc - s0;
        end
        oe_prev <= oe;
    end

    // SRAM model: captures command/address on SCK rise, presents data for that period
    int          mode = 0;
    int          r_n = 0;
    logic [7:0]  op_cap = 8'h0;
    logic [23:0] a_cap = 24'h0;

    function automatic logic [7:0] mem_byte(input logic [23:0] b, input int m);
        logic [31:0] pat;
        pat = 32'hDEADBEEF;
        if (m == 1) return b[7:0];
        return pat[31 - 8*int'(b[1:0]) -: 8];
    endfunction

    always @(posedge sck or posedge nce) begin
        int r, idx;
        logic [7:0] bt;
        if (nce) begin
            r_n <= 0;
            sram_q <= 4'h0;
        end else begin
            r = r_n + 1;
            if (r <= 8) op_cap <= {op_cap[6:0], qout[0]};
            else if (r <= 14) a_cap <= {a_cap[19:0], qout};
            if (r >= 15 + DUM) begin
                idx = r - 15 - DUM;
                bt = mem_byte(a_cap + 24'(idx / 2), mode);
                sram_q <= (idx % 2 == 1) ? bt[3:0] : bt[7:4];
            end
            r_n <= r;
        end
    end

    int pass_n = 0, fail_n = 0, total = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) pass_n++;
        else begin
            fail_n++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic go(input logic [23:0] a, input logic [AW:0] c);
        @(posedge clk); #1;
        saddr = a; wcnt = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int k;
        k = 0;
        while (done_n == 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk({tag, "_in_time"}, 64'(k < budget), 64'd1);
        repeat (4) @(posedge clk);
    endtask

    task automatic wait_writes(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (wr_n < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk({tag, "_in_time"}, 64'(k < budget), 64'd1);
    endtask

    initial begin
        int bad, w;
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, w;
        // Reset held while other inputs toggle
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (nce !== 1'b1 || sck !== 1'b0 || oe !== 1'b0 || we !== 1'b0) bad++;
            start = 1'($urandom_range(0, 1));
            saddr = 24'($urandom);
            wcnt  = 11'($urandom_range(0, 1024));
            tog_q = 4'($urandom);
        end
        chk("reset_quiet", 64'(bad), 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_words", 64'(wdone), 64'd0);
        start = 1'b0;
        tog   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Single word, fixed DE AD BE EF pattern
        mode = 0;
        go(24'h000100, 11'd1);
        wait_done(300, "w1");
        chk("w1_opcode", 64'(op_cap), 64'hEB);
        chk("w1_addr", 64'(a_cap), 64'h000100);
        chk("w1_oe_fall", 64'(oe_fall_rel), 64'd29);
        chk("w1_first_we", 64'(first_we_rel), 64'd57);
        chk("w1_writes", 64'(wr_n), 64'd1);
        chk("w1_wa", 64'(wa_bad), 64'd0);
        chk("w1_wd", 64'(last_wd), 64'hDEADBEEF);
        chk("w1_nce_low", 64'(nce_low), 64'd56);
        chk("w1_done_at", 64'(done_rel), 64'd59);
        chk("w1_done_n", 64'(done_n), 64'd1);
        chk("w1_busy", {63'd0, busy}, 64'd0);
        chk("w1_words", 64'(wdone), 64'd1);

        // Full buffer, incrementing bytes
        mode = 1;
        go(24'h000000, 11'd1024);
        wait_done(20000, "full");
        chk("full_writes", 64'(wr_n), 64'd1024);
        chk("full_wa", 64'(wa_bad), 64'd0);
        chk("full_last_wd", 64'(last_wd), 64'hFCFDFEFF);
        chk("full_words", 64'(wdone), 64'd1024);
        chk("full_done_n", 64'(done_n), 64'd1);

        // Zero-length transfer
        go(24'h000200, 11'd0);
        wait_done(50, "zero");
        chk("zero_nce_low", 64'(nce_low), 64'd0);
        chk("zero_done_at", 64'(done_rel), 64'd3);
        chk("zero_writes", 64'(wr_n), 64'd0);
        chk("zero_words", 64'(wdone), 64'd0);

        // Second start during DATA is ignored
        go(24'h000010, 11'd4);
        wait_writes(1, 300, "ign");
        @(posedge clk); #1;
        saddr = 24'hABCDEF; wcnt = 11'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(400, "ign");
        repeat (100) @(posedge clk);
        chk("ign_writes", 64'(wr_n), 64'd4);
        chk("ign_done_n", 64'(done_n), 64'd1);
        chk("ign_last_wd", 64'(last_wd), 64'h1C1D1E1F);
        chk("ign_words", 64'(wdone), 64'd4);

        // Reset in the middle of word 3 of 4
        go(24'h000040, 11'd4);
        wait_writes(2, 400, "rst");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_nce", {63'd0, nce}, 64'd1);
        chk("rst_oe", {63'd0, oe}, 64'd0);
        chk("rst_sck", {63'd0, sck}, 64'd0);
        w = wr_n;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_no_write", 64'(wr_n), 64'(w));
        chk("rst_words", 64'(wdone), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        go(24'h000080, 11'd2);
        wait_done(300, "post");
        chk("post_writes", 64'(wr_n), 64'd2);
        chk("post_wa", 64'(wa_bad), 64'd0);
        chk("post_last_wd", 64'(last_wd), 64'h84858687);
        chk("post_done_n", 64'(done_n), 64'd1);

        $display("%0d/%0d checks passed", pass_n, total);
        $finish;
    end

endmodule
